// File: rtl/ldpc_io_pkg.sv
// ldpc_io_pkg: shared types and constants for the LDPC decoder I/O sequencer.
//   load_state_t : LLR load FSM states
//   read_state_t : hard-decision scan FSM states
//   FRAME_LLRS   : LLRs per frame (L*K*K)
//   SCAN_STEPS   : column reads per frame scan (L*K)
//   onehot()     : one-hot PE select of width K*K
package ldpc_io_pkg;
  localparam int LDPC_L             = 32;
  localparam int LDPC_K             = 6;
  localparam int LDPC_ADDR_WIDTH    = 5;
  localparam int LDPC_MESSAGE_WIDTH = 5;
  localparam int LDPC_DROP_FRAMES   = 2;
  localparam int FRAME_LLRS         = LDPC_L * LDPC_K * LDPC_K;
  localparam int SCAN_STEPS         = LDPC_L * LDPC_K;

  typedef enum logic [1:0] {L_IDLE, L_LOAD, L_WAIT} load_state_t;
  typedef enum logic [1:0] {R_IDLE, R_SEL, R_CAPT, R_OUT} read_state_t;

  function automatic logic [LDPC_K*LDPC_K-1:0] onehot(input int unsigned idx);
    logic [LDPC_K*LDPC_K-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    return one << idx;
  endfunction
endpackage

// File: rtl/ldpc_io_sequencer_if.sv
// ldpc_io_sequencer_if: all non-clock signals of the sequencer.
//   s_*            : LLR input stream (valid/ready)
//   ext_reset/en/pe_select/int_in/load_add_in : decoder load side
//   f_id/read_add_in/column_select/dec_out_fin : decoder readback side
//   m_*            : hard-decision output stream (valid/ready)
//   err_len        : sticky frame-length error
// master = sequencer, slave = surrounding logic.
interface ldpc_io_sequencer_if #(
  parameter int K             = ldpc_io_pkg::LDPC_K,
  parameter int ADDR_WIDTH    = ldpc_io_pkg::LDPC_ADDR_WIDTH,
  parameter int MESSAGE_WIDTH = ldpc_io_pkg::LDPC_MESSAGE_WIDTH
);
  logic                     s_valid, s_ready, s_last;
  logic [MESSAGE_WIDTH-1:0] s_llr;
  logic                     ext_reset, en;
  logic [K*K-1:0]           pe_select;
  logic [MESSAGE_WIDTH-1:0] int_in;
  logic [ADDR_WIDTH-1:0]    load_add_in;
  logic                     f_id;
  logic [ADDR_WIDTH-1:0]    read_add_in;
  logic [K-1:0]             column_select;
  logic [K*K-1:0]           dec_out_fin;
  logic                     m_valid, m_ready;
  logic [K*K-1:0]           m_data;
  logic [ADDR_WIDTH-1:0]    m_addr;
  logic                     err_len;

  modport master (
    input  s_valid, s_llr, s_last, f_id, dec_out_fin, m_ready,
    output s_ready, ext_reset, en, pe_select, int_in, load_add_in,
           read_add_in, column_select, m_valid, m_data, m_addr, err_len
  );
  modport slave (
    output s_valid, s_llr, s_last, f_id, dec_out_fin, m_ready,
    input  s_ready, ext_reset, en, pe_select, int_in, load_add_in,
           read_add_in, column_select, m_valid, m_data, m_addr, err_len
  );
endinterface

// File: rtl/ldpc_hd_reader.sv
// ldpc_hd_reader: scans decoder hard decisions after each completed frame.
// For every address it steps column_select through all K columns, captures
// dec_out_fin on the last column and offers it as one m_data word. The first
// DROP_FRAMES scans after reset are walked silently (decoder pipeline fill).
//   f_tog        : completed-frame pulse from the f_id edge detector
//   read_add_in/column_select : decoder read address / one-hot column
//   m_valid/m_ready/m_data/m_addr : output word stream
module ldpc_hd_reader
  import ldpc_io_pkg::*;
#(
  parameter int L           = LDPC_L,
  parameter int K           = LDPC_K,
  parameter int ADDR_WIDTH  = LDPC_ADDR_WIDTH,
  parameter int DROP_FRAMES = LDPC_DROP_FRAMES  // must be >= 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  f_tog,
  input  logic [K*K-1:0]        dec_out_fin,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH-1:0] read_add_in,
  output logic [K-1:0]          column_select,
  output logic                  m_valid,
  output logic [K*K-1:0]        m_data,
  output logic [ADDR_WIDTH-1:0] m_addr
);
  localparam int COL_W  = $clog2(K);
  localparam int DROP_W = $clog2(DROP_FRAMES + 1);

  read_state_t           rs, rs_nxt;
  logic [ADDR_WIDTH-1:0] addr;   // j / K
  logic [COL_W-1:0]      col;    // j % K
  logic [DROP_W-1:0]     drop;
  logic                  dropping, last_col, last_addr, advance;

  assign dropping      = (drop != '0);
  assign last_col      = (col == COL_W'(K-1));
  assign last_addr     = (addr == ADDR_WIDTH'(L-1));
  // dropped frames advance without waiting for the consumer
  assign advance       = (rs == R_OUT) && (dropping || m_ready);
  assign m_valid       = (rs == R_OUT) && !dropping;
  assign read_add_in   = addr;
  assign column_select = (rs == R_SEL || rs == R_CAPT) ?
                         ({{(K-1){1'b0}}, 1'b1} << col) : '0;

  always_comb begin
    rs_nxt = rs;
    case (rs)
      R_IDLE:  if (f_tog) rs_nxt = R_SEL;
      R_SEL:   rs_nxt = R_CAPT;
      R_CAPT:  rs_nxt = last_col ? R_OUT : R_SEL;
      R_OUT:   if (advance) rs_nxt = last_addr ? R_IDLE : R_SEL;
      default: rs_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs     <= R_IDLE;
      addr   <= '0;
      col    <= '0;
      drop   <= DROP_W'(DROP_FRAMES);
      m_data <= '0;
      m_addr <= '0;
    end else begin
      rs <= rs_nxt;
      if (rs == R_CAPT) begin
        if (last_col) begin
          m_data <= dec_out_fin;
          m_addr <= addr;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (advance) begin
        col  <= '0;
        addr <= last_addr ? '0 : addr + 1'b1;
        if (last_addr && dropping) drop <= drop - 1'b1;
      end
    end
  end
endmodule

// File: rtl/ldpc_io_sequencer.sv
// ldpc_io_sequencer: front/back end for LDPC_Decoder.
// Load side: takes L*K*K LLRs per frame and writes them, one per cycle with
// one cycle of latency, to PE i/L at address i%L. A frame begins with an
// ext_reset pulse; after the frame the FSM waits for the decoder's f_id
// toggle before accepting the next one. Read side lives in ldpc_hd_reader.
//   clk, reset (async active-low), io (ldpc_io_sequencer_if.master)
module ldpc_io_sequencer
  import ldpc_io_pkg::*;
#(
  parameter int L             = LDPC_L,
  parameter int K             = LDPC_K,
  parameter int ADDR_WIDTH    = LDPC_ADDR_WIDTH,  // log2(L), L a power of two
  parameter int MESSAGE_WIDTH = LDPC_MESSAGE_WIDTH,
  parameter int DROP_FRAMES   = LDPC_DROP_FRAMES
) (
  input  logic                clk,
  input  logic                reset,
  ldpc_io_sequencer_if.master io
);
  localparam int FRAME_N = L * K * K;
  localparam int CNT_W   = $clog2(FRAME_N);

  load_state_t              ls, ls_nxt;
  logic [CNT_W-1:0]         cnt;
  logic                     f_id_q, f_tog, accept, last_idx, start;
  logic                     ext_reset_q, en_q, err_q;
  logic [K*K-1:0]           pe_sel_q;
  logic [MESSAGE_WIDTH-1:0] int_q;
  logic [ADDR_WIDTH-1:0]    load_add_q;

  assign f_tog    = io.f_id ^ f_id_q;
  assign io.s_ready = (ls == L_LOAD);
  assign accept   = io.s_valid & io.s_ready;
  assign last_idx = (cnt == CNT_W'(FRAME_N-1));
  assign start    = (ls == L_IDLE) && io.s_valid;

  assign io.ext_reset   = ext_reset_q;
  assign io.en          = en_q;
  assign io.pe_select   = pe_sel_q;
  assign io.int_in      = int_q;
  assign io.load_add_in = load_add_q;
  assign io.err_len     = err_q;

  // a toggle arriving with the last accept is deliberately not seen by
  // L_LOAD, so the FSM then waits for the following toggle
  always_comb begin
    ls_nxt = ls;
    case (ls)
      L_IDLE:  if (io.s_valid) ls_nxt = L_LOAD;
      L_LOAD:  if (accept && (last_idx || io.s_last)) ls_nxt = L_WAIT;
      L_WAIT:  if (f_tog) ls_nxt = L_IDLE;
      default: ls_nxt = L_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ls          <= L_IDLE;
      cnt         <= '0;
      f_id_q      <= 1'b0;
      ext_reset_q <= 1'b0;
      en_q        <= 1'b0;
      err_q       <= 1'b0;
      pe_sel_q    <= '0;
      int_q       <= '0;
      load_add_q  <= '0;
    end else begin
      ls          <= ls_nxt;
      f_id_q      <= io.f_id;
      ext_reset_q <= start;
      if (start) en_q <= 1'b1;
      pe_sel_q <= '0;
      if (accept) begin
        // L is a power of two: PE index and address are bit fields of cnt
        pe_sel_q   <= onehot(32'(cnt >> ADDR_WIDTH));
        load_add_q <= cnt[ADDR_WIDTH-1:0];
        int_q      <= io.s_llr;
        cnt        <= (last_idx || io.s_last) ? '0 : cnt + 1'b1;
        // s_last early, or missing on the final index
        if (last_idx != io.s_last) err_q <= 1'b1;
      end
    end
  end

  ldpc_hd_reader #(
    .L(L), .K(K), .ADDR_WIDTH(ADDR_WIDTH), .DROP_FRAMES(DROP_FRAMES)
  ) u_hd (
    .clk           (clk),
    .reset         (reset),
    .f_tog         (f_tog),
    .dec_out_fin   (io.dec_out_fin),
    .m_ready       (io.m_ready),
    .read_add_in   (io.read_add_in),
    .column_select (io.column_select),
    .m_valid       (io.m_valid),
    .m_data        (io.m_data),
    .m_addr        (io.m_addr)
  );
endmodule

// File: tb/tb_ldpc_io_sequencer.sv
module tb_ldpc_io_sequencer;
  import ldpc_io_pkg::*;
  localparam int NPE = LDPC_K * LDPC_K;
  localparam int NL  = FRAME_LLRS;
  localparam int NW  = LDPC_L;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ldpc_io_sequencer_if ifc ();
  ldpc_io_sequencer dut (.clk(clk), .reset(rst_n), .io(ifc.master));

  // decoder stub: hard decisions depend only on the read address
  function automatic logic [NPE-1:0] pattern(input logic [4:0] a);
    return {6{1'b1, a}} ^ 36'h9_3C5A_F0E1;
  endfunction
  assign ifc.dec_out_fin = pattern(ifc.read_add_in);

  typedef struct packed { logic [NPE-1:0] pe; logic [4:0] addr; logic [4:0] llr; } ld_t;
  typedef struct packed { logic [4:0] addr; logic [NPE-1:0] data; } wd_t;
  ld_t ld_q[$];
  wd_t wd_q[$];
  logic [4:0] exp_llr[$];
  int ext_pulses, mv_cycles;
  int scans;  // scans started since reset
  int vectors = 0, miscompares = 0;

  always @(negedge clk) if (rst_n) begin
    if (ifc.pe_select != '0) ld_q.push_back({ifc.pe_select, ifc.load_add_in, ifc.int_in});
    if (ifc.ext_reset) ext_pulses++;
    if (ifc.m_valid) mv_cycles++;
    if (ifc.m_valid && ifc.m_ready) wd_q.push_back({ifc.m_addr, ifc.m_data});
  end

  function automatic logic [102:0] all_outs();
    return {ifc.s_ready, ifc.ext_reset, ifc.en, ifc.pe_select, ifc.int_in, ifc.load_add_in,
            ifc.read_add_in, ifc.column_select, ifc.m_valid, ifc.m_data, ifc.m_addr, ifc.err_len};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic toggle_fid();
    ifc.f_id = ~ifc.f_id;
    tick();
    scans++;
  endtask

  task automatic wait_words(input int n, input int budget);
    int c = 0;
    while (wd_q.size() < n && c < budget) begin tick(); c++; end
  endtask

  // drive one frame of n LLRs; s_last at index last_at (-1: never)
  task automatic send_frame(input int n, input int last_at, input bit rnd_valid, input bit rnd_llr);
    logic [4:0] v; bit rdy, acc; int guard;
    exp_llr.delete(); ld_q.delete(); ext_pulses = 0;
    for (int i = 0; i < n; i++) begin
      v = rnd_llr ? 5'($urandom) : 5'(i % 32);
      guard = 0; acc = 0;
      while (!acc && guard < 64) begin
        ifc.s_valid = rnd_valid ? ($urandom_range(0, 2) != 0) : 1'b1;
        ifc.s_llr   = v;
        ifc.s_last  = (i == last_at);
        @(negedge clk); rdy = ifc.s_ready;
        @(posedge clk); #1;
        acc = ifc.s_valid && rdy;
        guard++;
      end
      if (!acc) break;
      exp_llr.push_back(v);
    end
    ifc.s_valid = 1'b0; ifc.s_last = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    ifc.s_valid = 0; ifc.s_last = 0; ifc.s_llr = 0; ifc.f_id = 0; ifc.m_ready = 1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    scans = 0; mv_cycles = 0; ext_pulses = 0;
    tick();
  endtask

  task automatic test_reset();
    ifc.s_valid = 0; ifc.s_last = 0; ifc.s_llr = 0; ifc.f_id = 0; ifc.m_ready = 1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (all_outs() !== '0) begin miscompares++; $display("FAIL reset_outs got=%h exp=0", all_outs()); end
    rst_n = 1'b1; scans = 0; mv_cycles = 0;
    tick();
    vectors++;
    if (all_outs() !== '0) begin miscompares++; $display("FAIL idle_outs got=%h exp=0", all_outs()); end
  endtask

  task automatic test_load_order();
    logic [NPE-1:0] one = 1;
    ld_t exp;
    send_frame(NL, NL-1, 0, 0);
    vectors++;
    if (ext_pulses !== 1) begin miscompares++; $display("FAIL ext_reset_pulses got=%0d exp=1", ext_pulses); end
    vectors++;
    if (ifc.en !== 1'b1) begin miscompares++; $display("FAIL en got=%b exp=1", ifc.en); end
    vectors++;
    if (ld_q.size() !== NL) begin miscompares++; $display("FAIL load_count got=%0d exp=%0d", ld_q.size(), NL); end
    for (int k = 0; k < ld_q.size() && k < NL; k++) begin
      exp = {one << (k / 32), 5'(k % 32), 5'(k % 32)};
      vectors++;
      if (ld_q[k] !== exp) begin
        miscompares++; $display("FAIL load_seq[%0d] got=%h exp=%h", k, ld_q[k], exp); break;
      end
    end
    if (ld_q.size() > 33) begin
      vectors++;
      if (ld_q[33].pe !== 36'h2 || ld_q[33].addr !== 5'd1 || ld_q[33].llr !== 5'd1) begin
        miscompares++; $display("FAIL load_i33 got=%h exp pe=2 addr=1 llr=1", ld_q[33]);
      end
    end
    vectors++;
    if (ifc.s_ready !== 1'b0) begin miscompares++; $display("FAIL ready_after_last got=%b exp=0", ifc.s_ready); end
    vectors++;
    if (ifc.err_len !== 1'b0) begin miscompares++; $display("FAIL err_len_clean got=%b exp=0", ifc.err_len); end
    toggle_fid();
  endtask

  task automatic test_backpressure();
    logic [NPE-1:0] one = 1;
    ld_t exp;
    send_frame(NL, NL-1, 1, 1);
    vectors++;
    if (ld_q.size() !== NL) begin miscompares++; $display("FAIL bp_pe_cycles got=%0d exp=%0d", ld_q.size(), NL); end
    for (int k = 0; k < ld_q.size() && k < exp_llr.size(); k++) begin
      exp = {one << (k / 32), 5'(k % 32), exp_llr[k]};
      vectors++;
      if (ld_q[k] !== exp) begin
        miscompares++; $display("FAIL bp_seq[%0d] got=%h exp=%h", k, ld_q[k], exp); break;
      end
    end
    vectors++;
    if (ext_pulses !== 1) begin miscompares++; $display("FAIL bp_ext_reset got=%0d exp=1", ext_pulses); end
    toggle_fid();
  endtask

  task automatic test_drop_frames();
    send_frame(NL, NL-1, 0, 1);
    vectors++;
    if (mv_cycles !== 0) begin miscompares++; $display("FAIL drop_no_valid got=%0d exp=0", mv_cycles); end
    wd_q.delete();
    toggle_fid();
    wait_words(NW, 1000);
    vectors++;
    if (wd_q.size() !== NW) begin miscompares++; $display("FAIL frame3_words got=%0d exp=%0d", wd_q.size(), NW); end
    for (int k = 0; k < wd_q.size(); k++) begin
      vectors++;
      if (wd_q[k] !== {5'(k), pattern(5'(k))}) begin
        miscompares++; $display("FAIL frame3_word[%0d] got=%h exp=%h", k, wd_q[k], {5'(k), pattern(5'(k))}); break;
      end
    end
  endtask

  task automatic test_output_stall();
    int c = 0; int after7 = 0;
    send_frame(NL, NL-1, 1, 1);
    wd_q.delete();
    toggle_fid();
    while (!(ifc.m_valid && ifc.m_addr == 5'd7) && c < 2000) begin tick(); c++; end
    ifc.m_ready = 1'b0;
    vectors++;
    if (c >= 2000) begin miscompares++; $display("FAIL stall_reach_addr7 timeout got=%0d cycles", c); end
    for (int s = 0; s < 5; s++) begin
      tick();
      vectors++;
      if ({ifc.m_valid, ifc.m_addr, ifc.m_data, ifc.column_select} !== {1'b1, 5'd7, pattern(5'd7), 6'd0}) begin
        miscompares++;
        $display("FAIL stall_hold[%0d] got v=%b a=%0d d=%h cs=%h exp v=1 a=7 d=%h cs=0",
                 s, ifc.m_valid, ifc.m_addr, ifc.m_data, ifc.column_select, pattern(5'd7));
      end
    end
    ifc.m_ready = 1'b1;
    wait_words(NW, 1000);
    vectors++;
    if (wd_q.size() !== NW) begin miscompares++; $display("FAIL stall_words got=%0d exp=%0d", wd_q.size(), NW); end
    for (int k = 0; k < wd_q.size(); k++) begin
      if (wd_q[k].addr > 5'd7) after7++;
      vectors++;
      if (wd_q[k] !== {5'(k), pattern(5'(k))}) begin
        miscompares++; $display("FAIL stall_word[%0d] got=%h exp=%h", k, wd_q[k], {5'(k), pattern(5'(k))}); break;
      end
    end
    vectors++;
    if (after7 !== 24) begin miscompares++; $display("FAIL stall_remaining got=%0d exp=24", after7); end
  endtask

  task automatic test_len_err();
    int held;
    send_frame(NL, 100, 0, 1);
    vectors++;
    if (ld_q.size() !== 101) begin miscompares++; $display("FAIL trunc_count got=%0d exp=101", ld_q.size()); end
    vectors++;
    if ({ifc.err_len, ifc.s_ready} !== 2'b10) begin
      miscompares++; $display("FAIL trunc_err_wait got err=%b rdy=%b exp err=1 rdy=0", ifc.err_len, ifc.s_ready);
    end
    held = ld_q.size(); ext_pulses = 0;
    ifc.s_valid = 1'b1;
    repeat (10) tick();
    ifc.s_valid = 1'b0;
    tick();
    vectors++;
    if (ld_q.size() !== held || ext_pulses !== 0) begin
      miscompares++; $display("FAIL wait_blocks got loads=%0d pulses=%0d exp loads=%0d pulses=0", ld_q.size(), ext_pulses, held);
    end
    toggle_fid();
    send_frame(NL, -1, 1, 1);
    vectors++;
    if ({ext_pulses, ld_q.size()} !== {32'd1, 32'(NL)}) begin
      miscompares++; $display("FAIL refill got pulses=%0d loads=%0d exp 1 %0d", ext_pulses, ld_q.size(), NL);
    end
    vectors++;
    if ({ifc.err_len, ifc.s_ready} !== 2'b10) begin
      miscompares++; $display("FAIL nolast_sticky got err=%b rdy=%b exp err=1 rdy=0", ifc.err_len, ifc.s_ready);
    end
    wd_q.delete();
    toggle_fid();
  endtask

  task automatic test_async_reset();
    int c = 0;
    while (!(ifc.m_valid && ifc.m_addr == 5'd12) && c < 2000) begin tick(); c++; end
    vectors++;
    if (c >= 2000) begin miscompares++; $display("FAIL arst_reach_addr12 timeout got=%0d cycles", c); end
    #2;
    rst_n = 1'b0;
    ifc.f_id = 1'b0;
    #1;
    vectors++;
    if (all_outs() !== '0) begin miscompares++; $display("FAIL arst_outs got=%h exp=0", all_outs()); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; scans = 0; mv_cycles = 0;
    tick();
    for (int f = 0; f < 2; f++) begin
      send_frame(NL, NL-1, 1, 1);
      toggle_fid();
    end
    send_frame(NL, NL-1, 0, 1);
    vectors++;
    if (mv_cycles !== 0) begin miscompares++; $display("FAIL arst_redrop got=%0d exp=0", mv_cycles); end
    wd_q.delete();
    toggle_fid();
    wait_words(NW, 1000);
    vectors++;
    if (wd_q.size() !== NW) begin miscompares++; $display("FAIL arst_words got=%0d exp=%0d", wd_q.size(), NW); end
    for (int k = 0; k < wd_q.size(); k++) begin
      vectors++;
      if (wd_q[k] !== {5'(k), pattern(5'(k))}) begin
        miscompares++; $display("FAIL arst_word[%0d] got=%h exp=%h", k, wd_q[k], {5'(k), pattern(5'(k))}); break;
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_order();
    test_backpressure();
    test_drop_frames();
    test_output_stall();
    test_len_err();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ldpc_io_sequencer.md
Name: ldpc_io_sequencer

Overview:
Synthesizable front/back end for LDPC_Decoder. It accepts a stream of 5-bit intrinsic LLRs over valid/ready, and generates the decoder load interface: pe_select, int_in, load_add_in, en and ext_reset. It also scans the decoder's hard-decision output through read_add_in and column_select, then streams one K*K-bit word per circulant address. This replaces the bench-only frame driver with RTL suitable for the device top.

Parameters:
L, 32, circulant size (addresses per PE)
K, 6, block rows/columns; decoder has K*K PEs
ADDR_WIDTH, 5, log2(L)
MESSAGE_WIDTH, 5, LLR width
DROP_FRAMES, 2, decoder pipeline-fill frames whose output is discarded after reset

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-low
s_valid  in  1  LLR valid
s_ready  out  1  LLR accept
s_llr  in  MESSAGE_WIDTH  intrinsic LLR, frame order index 0..L*K*K-1
s_last  in  1  last LLR of frame
ext_reset  out  1  one-cycle decoder frame-start pulse
en  out  1  decoder enable
pe_select  out  K*K  one-hot PE write select
int_in  out  MESSAGE_WIDTH  LLR to decoder
load_add_in  out  ADDR_WIDTH  PE memory address
f_id  in  1  decoder frame id; a toggle marks a completed frame
read_add_in  out  ADDR_WIDTH  hard-decision read address
column_select  out  K  one-hot column select
dec_out_fin  in  K*K  hard decisions; bit [x*K+y] = block row x, column y
m_valid  out  1  output word valid
m_ready  in  1  output accept
m_data  out  K*K  hard decisions for one address; bit [x*K+y]
m_addr  out  ADDR_WIDTH  address of m_data
err_len  out  1  sticky frame-length error

Behaviour:
- Reset values: all outputs 0. Both FSMs go idle, all counters clear, and the drop counter loads DROP_FRAMES. Reset taking effect mid-frame abandons that frame with no partial output.
- Load FSM, L_IDLE:
  - s_ready=0.
  - On s_valid=1: pulse ext_reset for 1 cycle, set en=1 (en stays 1 until reset), go to L_LOAD.
- Load FSM, L_LOAD:
  - s_ready=1.
  - On each accepted LLR with index i (11-bit counter): on the next cycle, pe_select=one-hot(i/L), load_add_in=i%L, int_in=s_llr.
  - pe_select returns to 0 on any cycle with no accept.
  - Latency is 1 cycle; throughput is 1 LLR per cycle.
- End of frame: on accept of i=L*K*K-1, go to L_WAIT.
- Length errors:
  - s_last=1 at i<L*K*K-1: err_len=1, go to L_WAIT (frame truncated).
  - s_last=0 at i=L*K*K-1: err_len=1, frame still treated as complete.
- L_WAIT: s_ready=0. On detected f_id toggle go to L_IDLE, so the next frame's ext_reset follows.
- f_id edge detect: register f_id. A toggle is current != registered. The toggle pulse is shared by both FSMs.
- Read FSM, R_IDLE: on f_id toggle, start a scan with j=0; j counts 0..L*K-1.
- Read FSM, R_SEL: drive read_add_in=j/K and column_select=one-hot(j%K). Go to R_CAPT next cycle.
- R_CAPT:
  - When j%K==K-1: register dec_out_fin into m_data, set m_addr=j/K, go to R_OUT.
  - Otherwise: j++, back to R_SEL.
  - column_select is 0 outside R_SEL/R_CAPT.
- R_OUT:
  - m_valid=1 only if the drop counter is 0. m_data and m_addr are held stable while m_valid=1 and m_ready=0.
  - On handshake, or immediately if the frame is being dropped: j++. If j wraps past L*K-1, go to R_IDLE and decrement the drop counter (saturating at 0); else go to R_SEL.
- f_id toggle while a scan is active: ignored by the read FSM. Still counts for the load FSM.
- Simultaneous f_id toggle and last LLR accept: the load FSM goes to L_WAIT this cycle and waits for the next toggle.

Decomposition:
- Package ldpc_io_pkg: load_state_t {L_IDLE,L_LOAD,L_WAIT}, read_state_t {R_IDLE,R_SEL,R_CAPT,R_OUT}, constant FRAME_LLRS=L*K*K, constant SCAN_STEPS=L*K, and a onehot function.
- One natural sub-module: ldpc_hd_reader, containing the read FSM, drop counter and output register. The load FSM stays at top level.

Test Plan:
- Load order: stream 1152 LLRs with s_llr=i%32, s_last at 1151 -> ext_reset one pulse; i=33 appears as pe_select=36'h2, load_add_in=1, int_in=1; s_ready=0 after the last accept.
- Backpressure on load: toggle s_valid randomly -> pe_select nonzero exactly 1152 cycles; no index skipped or duplicated.
- Drop frames: run 3 frames, toggling f_id after each, with a stub returning dec_out_fin=m_addr-derived pattern -> no m_valid for frames 1-2; frame 3 yields 32 words, m_addr 0..31 in order, m_data matching the stub.
- Output stall: m_ready low 5 cycles at m_addr=7 -> m_data/m_addr held; no column_select activity during the stall; the remaining 24 words are then delivered.
- Length error: s_last at i=100 -> err_len=1, load FSM in L_WAIT; a later f_id toggle allows a new frame; err_len stays 1 until reset.
- Async reset mid-scan at m_addr=12 -> all outputs 0 immediately; the next two frames are dropped again.
